// File: rtl/arf132b064e1r1w0cbbehbaa4acw_rcb_pkg.sv
// Shared types and parameter limits for the multi-channel regional clock buffer.
package arf132b064e1r1w0cbbehbaa4acw_rcb_pkg;

    typedef enum logic [1:0] {OFF, WAKE, ON, HOLD} rcb_state_t;

    localparam int WAKE_CNT_W   = 3;
    localparam int NUM_CH_MIN   = 1;
    localparam int NUM_CH_MAX   = 16;
    localparam int WAKE_LAT_MIN = 1;
    localparam int WAKE_LAT_MAX = 7;

    function automatic bit rcb_params_ok(input int num_ch, input int wake_lat, input int idle_w);
        return (num_ch >= NUM_CH_MIN) && (num_ch <= NUM_CH_MAX) &&
               (wake_lat >= WAKE_LAT_MIN) && (wake_lat <= WAKE_LAT_MAX) && (idle_w >= 1);
    endfunction

endpackage

// File: rtl/arf132b064e1r1w0cbbehbaa4acw_rcb_and.sv
// Per-channel clock AND cell with a low-phase enable latch so enable changes never chop a pulse.
module arf132b064e1r1w0cbbehbaa4acw_rcb_and (
    input  logic ck_i,
    input  logic en_i,
    input  logic fd_i,
    input  logic rd_i,
    output logic ck_o
);
    logic en_l;

    always_latch begin
        if (!ck_i) en_l <= en_i;
    end

    assign ck_o = ck_i & en_l;

    // LCP trim bits only matter to the physical cell; the behavioural model ignores them.
    logic unused_lcp;
    assign unused_lcp = fd_i ^ rd_i;

endmodule

// File: rtl/arf132b064e1r1w0cbbehbaa4acw_rcb_ch_ctl.sv
// One-channel power-enable FSM: wake latency, idle-hold hysteresis, registered ChEn/Ready.
module arf132b064e1r1w0cbbehbaa4acw_rcb_ch_ctl
    import arf132b064e1r1w0cbbehbaa4acw_rcb_pkg::*;
#(
    parameter int IDLE_W   = 4,
    parameter int WAKE_LAT = 2
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              rpen_i,
    input  logic [IDLE_W-1:0] idle_dly_i,
    output logic              ch_en_o,
    output logic              ch_en_d_o,
    output logic              ready_o
);
    localparam logic [WAKE_CNT_W-1:0] WAKE_LOAD = WAKE_CNT_W'(WAKE_LAT - 1);

    rcb_state_t              state_q, state_d;
    logic [WAKE_CNT_W-1:0]   wake_cnt_q, wake_cnt_d;
    logic [IDLE_W-1:0]       idle_cnt_q, idle_cnt_d;
    logic                    rpen_q;
    logic                    ch_en_q, ch_en_d, ready_q, ready_d;

    // RPEn is registered first, which provides the one-edge lead before ChEn moves.
    always_comb begin
        state_d    = state_q;
        wake_cnt_d = wake_cnt_q;
        idle_cnt_d = idle_cnt_q;
        case (state_q)
            OFF: if (rpen_q) begin
                state_d    = WAKE;
                wake_cnt_d = WAKE_LOAD;
            end
            WAKE: if (wake_cnt_q == '0) state_d = ON;
                  else                  wake_cnt_d = wake_cnt_q - WAKE_CNT_W'(1);
            ON: if (!rpen_q) begin
                if (idle_dly_i == '0) state_d = OFF;
                else begin
                    state_d    = HOLD;
                    idle_cnt_d = idle_dly_i - IDLE_W'(1);
                end
            end
            HOLD: if (rpen_q) begin
                state_d    = ON;
                idle_cnt_d = '0;
            end else if (idle_cnt_q == '0) state_d = OFF;
            else idle_cnt_d = idle_cnt_q - IDLE_W'(1);
            default: state_d = OFF;
        endcase
        ch_en_d = (state_d != OFF);
        ready_d = (state_d == ON) || (state_d == HOLD);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= OFF;
            wake_cnt_q <= '0;
            idle_cnt_q <= '0;
            rpen_q     <= 1'b0;
            ch_en_q    <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wake_cnt_q <= wake_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            rpen_q     <= rpen_i;
            ch_en_q    <= ch_en_d;
            ready_q    <= ready_d;
        end
    end

    assign ch_en_o   = ch_en_q;
    assign ch_en_d_o = ch_en_d;
    assign ready_o   = ready_q;

endmodule

// File: rtl/blk_06e8e8.sv
// Multi-channel regional clock buffer controller: per-channel FSMs, override OR, AnyOn register.
module blk_06e8e8
    import arf132b064e1r1w0cbbehbaa4acw_rcb_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int IDLE_W   = 4,
    parameter int WAKE_LAT = 2
) (
    input  logic              CkGridX1N,
    input  logic              RstbX1N,
    input  logic [NUM_CH-1:0] RPEn,
    input  logic              RPOvrd,
    input  logic              FscanClkUngate,
    input  logic [IDLE_W-1:0] IdleDly,
    input  logic [NUM_CH-1:0] Fd,
    input  logic [NUM_CH-1:0] Rd,
    output logic [NUM_CH-1:0] CkRcbX1N,
    output logic [NUM_CH-1:0] Ready,
    output logic              AnyOn
);
    if (!rcb_params_ok(NUM_CH, WAKE_LAT, IDLE_W)) begin : g_bad_params
        $error("blk_06e8e8: parameter out of range");
    end

    logic [NUM_CH-1:0] ch_en, ch_en_d, en;
    logic              any_on_q;
    logic              force_on;

    // Overrides bypass the FSMs so they act without waiting for a state change.
    assign force_on = RPOvrd | FscanClkUngate;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        arf132b064e1r1w0cbbehbaa4acw_rcb_ch_ctl #(
            .IDLE_W   (IDLE_W),
            .WAKE_LAT (WAKE_LAT)
        ) u_ctl (
            .clk_i      (CkGridX1N),
            .rst_n_i    (RstbX1N),
            .rpen_i     (RPEn[i]),
            .idle_dly_i (IdleDly),
            .ch_en_o    (ch_en[i]),
            .ch_en_d_o  (ch_en_d[i]),
            .ready_o    (Ready[i])
        );

        assign en[i] = ch_en[i] | force_on;

        arf132b064e1r1w0cbbehbaa4acw_rcb_and u_and (
            .ck_i (CkGridX1N),
            .en_i (en[i]),
            .fd_i (Fd[i]),
            .rd_i (Rd[i]),
            .ck_o (CkRcbX1N[i])
        );
    end

    always_ff @(posedge CkGridX1N) begin
        if (!RstbX1N) any_on_q <= 1'b0;
        else          any_on_q <= |ch_en_d;
    end

    assign AnyOn = any_on_q;

endmodule

// File: tb/tb_blk_06e8e8.sv
// Scoreboard bench for blk_06e8e8: behavioural channel model feeds an expectation queue.
module tb_blk_06e8e8;
    localparam int NCH = 4;
    localparam int WL  = 2;

    logic           clk = 1'b0;
    logic           rstb;
    logic [NCH-1:0] rpen, fd, rd, ck_out, ready;
    logic           ovrd, scan, any_on;
    logic [3:0]     idly;

    blk_06e8e8 #(.NUM_CH(NCH), .IDLE_W(4), .WAKE_LAT(WL)) dut (
        .CkGridX1N      (clk),
        .RstbX1N        (rstb),
        .RPEn           (rpen),
        .RPOvrd         (ovrd),
        .FscanClkUngate (scan),
        .IdleDly        (idly),
        .Fd             (fd),
        .Rd             (rd),
        .CkRcbX1N       (ck_out),
        .Ready          (ready),
        .AnyOn          (any_on)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NCH-1:0] ready;
        logic           any;
        logic [NCH-1:0] ck;
        logic [NCH-1:0] fd;
        logic [NCH-1:0] rd;
        bit             cmp;
    } exp_t;

    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: 0=off 1=waking 2=on 3=holding
    int             m_st[NCH];
    int             m_wc[NCH];
    int             m_ic[NCH];
    logic [NCH-1:0] m_rp = '0;
    logic [NCH-1:0] m_chen = '0;
    logic [NCH-1:0] m_ready = '0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic [NCH-1:0] rp, input logic [3:0] idl, input logic rs);
        for (int c = 0; c < NCH; c++) begin
            if (!rs) begin
                m_st[c] = 0; m_wc[c] = 0; m_ic[c] = 0;
            end else begin
                case (m_st[c])
                    0: if (m_rp[c]) begin m_st[c] = 1; m_wc[c] = WL - 1; end
                    1: if (m_wc[c] == 0) m_st[c] = 2; else m_wc[c]--;
                    2: if (!m_rp[c]) begin
                        if (idl == 0) m_st[c] = 0;
                        else begin m_st[c] = 3; m_ic[c] = int'(idl) - 1; end
                    end
                    default: if (m_rp[c]) m_st[c] = 2;
                             else if (m_ic[c] == 0) m_st[c] = 0;
                             else m_ic[c]--;
                endcase
            end
            m_chen[c]  = (m_st[c] != 0);
            m_ready[c] = (m_st[c] >= 2);
        end
        m_rp = rs ? rp : '0;
    endtask

    task automatic step(input logic [NCH-1:0] rp, input logic ov, input logic sc,
                        input logic [3:0] idl, input logic rs, input bit cmp);
        exp_t e, g;
        rpen = rp; ovrd = ov; scan = sc; idly = idl; rstb = rs;
        fd = 4'($urandom_range(0, 15));
        rd = 4'($urandom_range(0, 15));
        // The latch holds what En was in the low phase before the edge: pre-edge ChEn plus overrides.
        e.ck = m_chen | {NCH{ov | sc}};
        model_edge(rp, idl, rs);
        e.ready = m_ready;
        e.any   = |m_chen;
        e.fd    = fd;
        e.rd    = rd;
        e.cmp   = cmp;
        sbq.push_back(e);
        @(posedge clk);
        #2;
        g = sbq.pop_front();
        if (g.cmp) begin
            chk("ready", ready, g.ready);
            chk("anyon", any_on, g.any);
            chk("ckrcb", ck_out, g.ck);
            chk("fd0", dut.g_ch[0].u_and.fd_i, g.fd[0]);
            chk("rd3", dut.g_ch[3].u_and.rd_i, g.rd[3]);
        end
    endtask

    task automatic run(input int n, input logic [NCH-1:0] rp, input logic ov, input logic sc,
                       input logic [3:0] idl);
        for (int k = 0; k < n; k++) step(rp, ov, sc, idl, 1'b1, 1'b1);
    endtask

    initial begin
        rstb = 1'b0; rpen = '0; ovrd = 1'b0; scan = 1'b0; idly = 4'd3; fd = '0; rd = '0;
        for (int c = 0; c < NCH; c++) begin m_st[c] = 0; m_wc[c] = 0; m_ic[c] = 0; end
        @(posedge clk); #2;
        step('0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b1);
        chk("rst_ready", ready, 0);
        chk("rst_anyon", any_on, 0);

        // wake ch0
        run(1, 4'b0001, 0, 0, 4'd3);
        run(1, 4'b0001, 0, 0, 4'd3);
        chk("t1_anyon", any_on, 1);
        chk("t1_ready_early", ready, 0);
        run(2, 4'b0001, 0, 0, 4'd3);
        chk("t1_ready", ready, 4'b0001);
        run(3, 4'b0001, 0, 0, 4'd3);

        // idle hysteresis, full drop
        run(4, 4'b0000, 0, 0, 4'd3);
        chk("t2_hold_ready", ready, 4'b0001);
        run(1, 4'b0000, 0, 0, 4'd3);
        chk("t2_drop_ready", ready, 0);
        // re-wake then reassert during HOLD
        run(5, 4'b0001, 0, 0, 4'd3);
        run(2, 4'b0000, 0, 0, 4'd3);
        run(6, 4'b0001, 0, 0, 4'd3);
        chk("t2_no_loss", ready, 4'b0001);

        // IdleDly=0 and one-cycle pulse on ch1
        run(6, 4'b0011, 0, 0, 4'd0);
        run(2, 4'b0001, 0, 0, 4'd0);
        chk("t3_fast_off", ready, 4'b0001);
        run(1, 4'b0101, 0, 0, 4'd0);
        run(1, 4'b0011, 0, 0, 4'd0);
        run(7, 4'b0001, 0, 0, 4'd0);

        // overrides on everything
        run(4, 4'b0000, 0, 0, 4'd0);
        run(3, 4'b0000, 1, 0, 4'd0);
        chk("t4_ovrd_ck", ck_out, 4'b1111);
        chk("t4_ovrd_ready", ready, 0);
        run(2, 4'b0000, 0, 0, 4'd0);
        run(3, 4'b0000, 0, 1, 4'd0);
        run(3, 4'b0000, 0, 0, 4'd0);
        chk("t4_gated", ck_out, 0);

        // reset with ch0 in HOLD and ch2 in WAKE
        run(6, 4'b0001, 0, 0, 4'd3);
        run(2, 4'b0100, 0, 0, 4'd3);
        step(4'b0101, 1'b0, 1'b0, 4'd3, 1'b0, 1'b1);
        chk("t5_rst_ready", ready, 0);
        chk("t5_rst_anyon", any_on, 0);
        run(6, 4'b0101, 0, 0, 4'd3);

        // crossed channel toggles
        run(6, 4'b1010, 0, 0, 4'd2);
        run(8, 4'b0101, 0, 0, 4'd2);

        // random soak, including IdleDly changes mid-HOLD and resets
        for (int k = 0; k < 80; k++)
            step(4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
                 4'($urandom_range(0, 4)), ($urandom_range(0, 24) != 0), 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/blk_06e8e8.md
Name: arf132b064e1r1w0cbbehbaa4acw_gclk_make_clk_and_rcb_mc

Overview:
Multi-channel regional clock buffer controller, the parametrised successor of the single-channel RCB. It produces NUM_CH gated regional clocks from the grid clock. Each channel has its own power-enable FSM, with wake-up latency, idle-hold hysteresis and a per-channel ready flag. It sits between the array power-management logic and the per-region clock cells, and keeps the global override and scan ungate.

Parameters:
NUM_CH, 4, number of regional clock channels (1..16)
IDLE_W, 4, width of the idle-hold delay input and counter
WAKE_LAT, 2, cycles from clock restart to Ready assertion (1..7)

Ports:
CkGridX1N  input  1  grid clock; drives all FSM flops, which are ungated
RstbX1N  input  1  reset, synchronous, active-low
RPEn  input  NUM_CH  per-channel regional power enable (1 = functional)
RPOvrd  input  1  global power override; forces all clocks on
FscanClkUngate  input  1  scan ungate; forces all clocks on
IdleDly  input  IDLE_W  idle-hold cycles before gating; shared by all channels and sampled on entry to HOLD
Fd  input  NUM_CH  per-channel LCP bit, passed through to the clock cell
Rd  input  NUM_CH  per-channel LCP bit, passed through to the clock cell
CkRcbX1N  output  NUM_CH  gated regional clocks
Ready  output  NUM_CH  channel clock stable and usable
AnyOn  output  1  OR of all channel enables, for the upstream grid gater

Behaviour:
- Interface: one clock, CkGridX1N; reset RstbX1N is synchronous and active-low.
- Per-channel FSM states: OFF, WAKE, ON, HOLD. Next-state logic is registered.
- OFF
  - ChEn=0, Ready=0.
  - RPEn[i]=1: go to WAKE and load WakeCnt=WAKE_LAT-1.
- WAKE
  - ChEn=1, Ready=0.
  - WakeCnt decrements each cycle.
  - WakeCnt==0: go to ON.
  - RPEn[i] dropping during WAKE does not abort the wake; the FSM completes to ON, then follows the ON rules.
- ON
  - ChEn=1, Ready=1.
  - RPEn[i]=0: if IdleDly==0, go to OFF. Otherwise go to HOLD and load IdleCnt=IdleDly-1.
- HOLD
  - ChEn=1, Ready=1.
  - RPEn[i]=1: go to ON and discard the count.
  - Else, IdleCnt==0: go to OFF.
  - Else: decrement IdleCnt.
- Clock enable: En[i] = ChEn[i] | RPOvrd | FscanClkUngate. The override path is combinational, so overrides take effect without an FSM cycle. ChEn is a flop.
- En[i] drives the enable of the per-channel rcb_and cell. The glitch-free enable latch is inside that cell; no latch is coded here.
- Overrides do not change FSM state or Ready. Ready reflects only the FSM.
- Latency:
  - RPEn[i] sampled high at edge k: ChEn=1 after edge k+1.
  - First gated pulse occurs in the next high phase.
  - Ready=1 after edge k+1+WAKE_LAT.
- Idle gating: RPEn[i] sampled low at edge k in ON gives ChEn=0 after edge k+1+IdleDly. Ready falls on the same edge.
- Counter widths:
  - WakeCnt is 3 bits.
  - IdleCnt is IDLE_W bits.
  - Neither counter ever underflows; transitions occur at 0.
- IdleDly changes while a channel is in HOLD do not affect that channel.
- AnyOn = OR over ChEn. It is registered and has the same timing as ChEn.
- Channels are fully independent; simultaneous events on different channels do not interact.
- Reset:
  - While RstbX1N=0 at an edge, all FSMs go to OFF; ChEn=0, Ready=0, AnyOn=0, and all counters are 0.
  - Reset mid-WAKE or mid-HOLD gates the clock after that edge, unless an override is active.
  - CkRcbX1N is low when gated. Its reset value is gated (0) unless RPOvrd or FscanClkUngate is set.
- Fd and Rd pass through to the cell unregistered.

Decomposition:
- Package arf132b064e1r1w0cbbehbaa4acw_rcb_pkg:
  - enum rcb_state_t {OFF, WAKE, ON, HOLD}, 2 bits.
  - WAKE_CNT_W=3.
  - Parameter range-check localparams.
- Sub-module arf132b064e1r1w0cbbehbaa4acw_rcb_ch_ctl: one-channel FSM plus counters, outputs ChEn and Ready.
- The top level contains:
  - a generate loop over NUM_CH instantiating rcb_ch_ctl and arf132b064e1r1w0cbbehbaa4acw_rcb_and;
  - the override OR;
  - the AnyOn register.

Test Plan:
1. Wake: NUM_CH=4, WAKE_LAT=2, IdleDly=3; RPEn=0001 sampled at edge 10 -> ChEn[0]=1 after edge 11, Ready[0]=1 after edge 13, CkRcbX1N[0] pulses from cycle 12, other channels stay gated, AnyOn=1 after edge 11.
2. Idle hysteresis: from ON, RPEn[0]=0 at edge 20 -> Ready[0] and ChEn[0] stay 1 through edge 23 and drop after edge 24; RPEn[0] reasserted at edge 22 -> stays ON with no clock loss.
3. IdleDly=0: RPEn[1] deasserts in ON at edge 30 -> ChEn[1]=0 and Ready[1]=0 after edge 31. RPEn[1] pulsed for one cycle while OFF -> full WAKE, then ON, then OFF.
4. Overrides: all channels OFF, RPOvrd=1 -> all CkRcbX1N toggle within the same cycle and Ready stays 0000. FscanClkUngate behaves identically. Deasserting the override -> clocks gate again.
5. Reset mid-operation: ch0 in HOLD (IdleCnt=2) and ch2 in WAKE; RstbX1N=0 for 1 edge -> all OFF, Ready=0000, AnyOn=0, clocks gated. Releasing reset with RPEn=0101 -> both channels wake again with full WAKE_LAT.
6. Simultaneous, independent channels: RPEn toggled 1010->0101 on one edge -> ch1 and ch3 enter HOLD while ch0 and ch2 enter WAKE, each with correct independent timing. Fd/Rd patterns pass through to the cell ports unchanged.
